johnson_seq_gen: RTL and testbench
==================================

# johnson_seq_gen

Parametrised Johnson (twisted-ring) sequence generator. It is the next generation of the team's fixed 4-bit Johnson counter, adding width, count enable, direction, parallel load, illegal-state self-correction, phase decode and a wrap pulse. It is used as a glitch-free multi-phase sequencer and as a clock-phase / timing-strobe source in the counter library.

## Interface
- `WIDTH`, default 4: number of ring bits; must be ≥ 2. The sequence length is 2·WIDTH.
- `PHASE_W`, default $clog2(2·WIDTH): width of the phase index. It is derived and must not be overridden.
- `clk`  in  1: rising-edge clock.
- `reset`  in  1: reset, synchronous, active-high.
- `en`  in  1: count enable; one step per cycle while high.
- `dir`  in  1: 0 = forward, 1 = reverse; sampled only when a step occurs.
- `load`  in  1: parallel load request.
- `load_val`  in  WIDTH: value to load.
- `count_out`  out  WIDTH: ring register state.
- `phase`  out  PHASE_W: index 0..2·WIDTH−1 of the current state.
- `phase_onehot`  out  2·WIDTH: one-hot decode of `phase`.
- `wrap`  out  1: single-cycle pulse when a count step enters phase 0.
- `err`  out  1: single-cycle pulse when an illegal state is corrected or an illegal load is rejected.

## Operation
- **Legal codes:** a value is legal iff, across bit pairs (i, i+1) for i = 0..WIDTH−2, at most one pair differs. That gives exactly 2·WIDTH legal codes.
- **Forward step:** q ← {q[WIDTH−2:0], ~q[WIDTH−1]}. For WIDTH = 4 the sequence is 0000→0001→0011→0111→1111→1110→1100→1000→0000.
- **Reverse step:** q ← {~q[0], q[WIDTH−1:1]}. This is the exact inverse of the forward step.
- **Priority per clock edge:** reset > load > en > hold.
- **reset:** q ← 0, `wrap` ← 0, `err` ← 0.
- **load with legal `load_val`:** q ← `load_val`, `err` ← 0.
- **load with illegal `load_val`:** q ← 0, `err` ← 1.
- **en with legal q:** step in direction `dir`.
- **en with illegal q:** q ← 0 instead of stepping, `err` ← 1. An illegal q can only arise from an upset, because loads are checked.
- **hold (en low):** q unchanged, even if illegal. No correction happens while holding.
- **Phase decode (combinational from q):** let k = popcount(q).
  - If q = 0, phase = 0.
  - Else if q[0] = 1, phase = k.
  - Else phase = 2·WIDTH − k.
  - `phase_onehot` = 1 << `phase`.
  - For illegal q, `phase` and `phase_onehot` are don't-care, but must be X-free.
- **`wrap`:** registered; high for the cycle after a legal step lands on q = 0. That covers forward from phase 2·WIDTH−1 and reverse from phase 1. Entry to 0 by reset, load or correction never raises `wrap`.
- **`err`:** registered; high for exactly one cycle per event.

## Timing
- **Reset values:** `count_out` = 0, `phase` = 0, `phase_onehot` = 1, `wrap` = 0, `err` = 0.
- **Step latency:** one clock. `count_out`, `phase` and `phase_onehot` change together, with no extra register stage on the decodes.
- **Flag alignment:** `wrap` and `err` update on the same edge as the q change that causes them.
- **Direction changes:** toggling `dir` between steps is legal and takes effect on the next step. With en held high, forward then reverse returns to the prior state.
- **Simultaneous requests:** load and en high together means load wins and no step occurs. reset together with anything else means reset wins.
- **Reset mid-sequence:** any phase goes to 0 on the next edge, and pending flags clear.
- **Continuous enable:** `wrap` pulses every 2·WIDTH cycles in either direction.

## Structure
- **Shared package `johnson_pkg`:**
  - function `johnson_legal(value, width)`.
  - function for the phase width ($clog2(2·WIDTH)).
  - localparam for the direction encodings FWD = 0, REV = 1.
- **Sub-module `johnson_decode`:** combinational; input q, outputs `legal`, `phase`, `phase_onehot`.
  - The top instantiates it twice: once on q and once on `load_val`, using only `legal` from the second instance.
- **Top level:** holds the q register, the priority mux and the `wrap`/`err` registers.

## Test plan
1. **Reset and forward run:** WIDTH = 4, reset for 1 cycle, then en = 1, dir = 0 for 9 cycles.
   - `count_out` steps 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000, 0001.
   - `phase` steps 1..7, 0, 1.
   - `wrap` is high only on the 0000 cycle.
2. **Reverse run:** from 0000 with dir = 1, `count_out` = 1000 with `phase` = 7, then 1100 with `phase` = 6. Later, stepping 0001→0000 raises `wrap`.
3. **Legal load versus enable:** load = 1, en = 1, `load_val` = 0111.
   - `count_out` = 0111, `phase` = 3, `err` = 0, and no step that cycle.
   - The next en cycle gives 1111.
4. **Illegal load:** load = 1, `load_val` = 0101 → `count_out` = 0000, `err` pulses for 1 cycle, `wrap` = 0.
5. **Upset correction:** force q = 1010 with en = 0.
   - While en stays low, q holds 1010 and `err` = 0.
   - Raising en gives `count_out` = 0000 and a single `err` pulse.
   - The following step gives 0001.
6. **Reset mid-run and width sweep:** assert reset at phase 5 together with load = 1 → `count_out` = 0, flags = 0. Rerun scenario 1 with WIDTH = 2 (period 4) and WIDTH = 8 (period 16, `phase` 4 bits).

Source files
------------

// File: rtl/johnson_pkg.sv
// rtl/johnson_pkg.sv - shared types and helpers for the Johnson sequence generator
package johnson_pkg;

  localparam int   MAX_W = 64;
  localparam logic FWD   = 1'b0;
  localparam logic REV   = 1'b1;

  function automatic int johnson_phase_w(input int width);
    return $clog2(2 * width);
  endfunction

  // A Johnson code has at most one transition between adjacent bits.
  function automatic logic johnson_legal(input logic [MAX_W-1:0] value, input int width);
    int diffs;
    diffs = 0;
    for (int i = 0; i < MAX_W - 1; i++) begin
      if (i < width - 1 && value[i] != value[i+1]) diffs++;
    end
    return (diffs <= 1);
  endfunction

endpackage

// File: rtl/johnson_decode.sv
// rtl/johnson_decode.sv - combinational legality check and phase decode of a Johnson code
module johnson_decode
  import johnson_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int PHASE_W = johnson_phase_w(WIDTH)
) (
  input  logic [WIDTH-1:0]   q,
  output logic               legal,
  output logic [PHASE_W-1:0] phase,
  output logic [2*WIDTH-1:0] phase_onehot
);

  int k;

  // Phases 1..W fill ones from bit 0; phases W+1..2W-1 drain them, leaving q[0] low.
  always_comb begin
    k     = $countones(q);
    legal = johnson_legal(MAX_W'(q), WIDTH);
    if (q == '0) begin
      phase = '0;
    end else if (q[0]) begin
      phase = PHASE_W'(k);
    end else begin
      phase = PHASE_W'(2 * WIDTH - k);
    end
    phase_onehot = (2 * WIDTH)'(1) << phase;
  end

endmodule

// File: rtl/johnson_seq_gen.sv
// rtl/johnson_seq_gen.sv - parametrised Johnson sequencer with load, direction, self-correction and flags
module johnson_seq_gen
  import johnson_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int PHASE_W = johnson_phase_w(WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               dir,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_val,
  output logic [WIDTH-1:0]   count_out,
  output logic [PHASE_W-1:0] phase,
  output logic [2*WIDTH-1:0] phase_onehot,
  output logic               wrap,
  output logic               err
);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_next;
  logic             q_legal;
  logic             load_legal;

  johnson_decode #(.WIDTH(WIDTH), .PHASE_W(PHASE_W)) u_dec_q (
    .q            (q),
    .legal        (q_legal),
    .phase        (phase),
    .phase_onehot (phase_onehot)
  );

  johnson_decode #(.WIDTH(WIDTH), .PHASE_W(PHASE_W)) u_dec_load (
    .q            (load_val),
    .legal        (load_legal),
    .phase        (),
    .phase_onehot ()
  );

  always_comb begin
    if (dir == REV) begin
      q_next = {~q[0], q[WIDTH-1:1]};
    end else begin
      q_next = {q[WIDTH-2:0], ~q[WIDTH-1]};
    end
  end

  // Holding never corrects: an upset value is only scrubbed when a step is requested.
  always_ff @(posedge clk) begin
    if (reset) begin
      q    <= '0;
      wrap <= 1'b0;
      err  <= 1'b0;
    end else begin
      wrap <= 1'b0;
      err  <= 1'b0;
      if (load) begin
        if (load_legal) begin
          q <= load_val;
        end else begin
          q   <= '0;
          err <= 1'b1;
        end
      end else if (en) begin
        if (q_legal) begin
          q    <= q_next;
          wrap <= (q_next == '0);
        end else begin
          q   <= '0;
          err <= 1'b1;
        end
      end
    end
  end

  assign count_out = q;

endmodule

// File: tb/tb_johnson_seq_gen.sv
// tb/tb_johnson_seq_gen.sv - directed vector bench for johnson_seq_gen at widths 2, 4 and 8
module tb_johnson_seq_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  logic       rst4 = 1'b0, ld4 = 1'b0, en4 = 1'b0, dir4 = 1'b0;
  logic [3:0] lv4  = '0;
  logic [3:0] cnt4;
  logic [2:0] ph4;
  logic [7:0] oh4;
  logic       wrap4, err4;

  logic       rsts = 1'b0, ens = 1'b0, zero = 1'b0;
  logic [1:0] lv2 = '0;
  logic [7:0] lv8 = '0;
  logic [1:0] cnt2;
  logic [1:0] ph2;
  logic [3:0] oh2;
  logic       wrap2, err2;
  logic [7:0] cnt8;
  logic [3:0] ph8;
  logic [15:0] oh8;
  logic       wrap8, err8;

  johnson_seq_gen #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(rst4), .en(en4), .dir(dir4), .load(ld4), .load_val(lv4),
    .count_out(cnt4), .phase(ph4), .phase_onehot(oh4), .wrap(wrap4), .err(err4)
  );

  johnson_seq_gen #(.WIDTH(2)) dut2 (
    .clk(clk), .reset(rsts), .en(ens), .dir(zero), .load(zero), .load_val(lv2),
    .count_out(cnt2), .phase(ph2), .phase_onehot(oh2), .wrap(wrap2), .err(err2)
  );

  johnson_seq_gen #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(rsts), .en(ens), .dir(zero), .load(zero), .load_val(lv8),
    .count_out(cnt8), .phase(ph8), .phase_onehot(oh8), .wrap(wrap8), .err(err8)
  );

  typedef struct {
    string      name;
    logic       rst, ld, en, dir;
    logic [3:0] lv;
    logic [3:0] cnt;
    logic [2:0] ph;
    logic       wrap, err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Expected W-bit Johnson code for a given phase, built from its fill/drain shape.
  function automatic logic [63:0] jcode(input int w, input int p);
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    if (p <= w) return (64'd1 << p) - 64'd1;
    return mask & ~((64'd1 << (p - w)) - 64'd1);
  endfunction

  initial begin
    vecs.push_back('{"reset",        1,0,0,0, 4'h0, 4'b0000, 3'd0, 0,0});
    vecs.push_back('{"fwd1",         0,0,1,0, 4'h0, 4'b0001, 3'd1, 0,0});
    vecs.push_back('{"fwd2",         0,0,1,0, 4'h0, 4'b0011, 3'd2, 0,0});
    vecs.push_back('{"fwd3",         0,0,1,0, 4'h0, 4'b0111, 3'd3, 0,0});
    vecs.push_back('{"fwd4",         0,0,1,0, 4'h0, 4'b1111, 3'd4, 0,0});
    vecs.push_back('{"fwd5",         0,0,1,0, 4'h0, 4'b1110, 3'd5, 0,0});
    vecs.push_back('{"fwd6",         0,0,1,0, 4'h0, 4'b1100, 3'd6, 0,0});
    vecs.push_back('{"fwd7",         0,0,1,0, 4'h0, 4'b1000, 3'd7, 0,0});
    vecs.push_back('{"fwd_wrap",     0,0,1,0, 4'h0, 4'b0000, 3'd0, 1,0});
    vecs.push_back('{"fwd9",         0,0,1,0, 4'h0, 4'b0001, 3'd1, 0,0});
    vecs.push_back('{"hold",         0,0,0,1, 4'h0, 4'b0001, 3'd1, 0,0});
    vecs.push_back('{"rev_wrap",     0,0,1,1, 4'h0, 4'b0000, 3'd0, 1,0});
    vecs.push_back('{"rev7",         0,0,1,1, 4'h0, 4'b1000, 3'd7, 0,0});
    vecs.push_back('{"rev6",         0,0,1,1, 4'h0, 4'b1100, 3'd6, 0,0});
    vecs.push_back('{"dir_flip",     0,0,1,0, 4'h0, 4'b1000, 3'd7, 0,0});
    vecs.push_back('{"load_vs_en",   0,1,1,0, 4'h7, 4'b0111, 3'd3, 0,0});
    vecs.push_back('{"after_load",   0,0,1,0, 4'h0, 4'b1111, 3'd4, 0,0});
    vecs.push_back('{"illegal_load", 0,1,0,0, 4'h5, 4'b0000, 3'd0, 0,1});
    vecs.push_back('{"err_clear",    0,0,0,0, 4'h0, 4'b0000, 3'd0, 0,0});
    vecs.push_back('{"load_ph7",     0,1,0,0, 4'h8, 4'b1000, 3'd7, 0,0});
    vecs.push_back('{"load_zero",    0,1,1,0, 4'h0, 4'b0000, 3'd0, 0,0});
    vecs.push_back('{"load_ph5",     0,1,0,0, 4'hE, 4'b1110, 3'd5, 0,0});
    vecs.push_back('{"rst_vs_load",  1,1,1,0, 4'h7, 4'b0000, 3'd0, 0,0});
    vecs.push_back('{"ill_then_rst", 0,1,0,0, 4'h9, 4'b0000, 3'd0, 0,1});
    vecs.push_back('{"rst_clr_err",  1,0,1,0, 4'h0, 4'b0000, 3'd0, 0,0});

    @(negedge clk);
    foreach (vecs[i]) begin
      rst4 = vecs[i].rst; ld4 = vecs[i].ld; en4 = vecs[i].en; dir4 = vecs[i].dir; lv4 = vecs[i].lv;
      step();
      check({vecs[i].name, ".count"},  64'(cnt4),  64'(vecs[i].cnt));
      check({vecs[i].name, ".phase"},  64'(ph4),   64'(vecs[i].ph));
      check({vecs[i].name, ".onehot"}, 64'(oh4),   64'(8'd1 << vecs[i].ph));
      check({vecs[i].name, ".wrap"},   64'(wrap4), 64'(vecs[i].wrap));
      check({vecs[i].name, ".err"},    64'(err4),  64'(vecs[i].err));
    end

    // Upset: corrupt the ring while holding, then request a step.
    rst4 = 1'b0; ld4 = 1'b0; en4 = 1'b0; dir4 = 1'b0;
    force dut4.q = 4'b1010;
    #1;
    release dut4.q;
    for (int c = 0; c < 2; c++) begin
      step();
      check("upset_hold.count", 64'(cnt4), 64'(4'b1010));
      check("upset_hold.err",   64'(err4), 64'd0);
    end
    en4 = 1'b1;
    step();
    check("upset_fix.count", 64'(cnt4),  64'(4'b0000));
    check("upset_fix.err",   64'(err4),  64'd1);
    check("upset_fix.wrap",  64'(wrap4), 64'd0);
    step();
    check("upset_next.count", 64'(cnt4), 64'(4'b0001));
    check("upset_next.err",   64'(err4), 64'd0);
    en4 = 1'b0;

    // Width sweep: WIDTH = 2 and WIDTH = 8 run forward together from reset.
    rsts = 1'b1;
    step();
    rsts = 1'b0;
    check("w2_reset.count", 64'(cnt2), 64'd0);
    check("w8_reset.count", 64'(cnt8), 64'd0);
    check("w8_reset.onehot", 64'(oh8), 64'd1);
    ens = 1'b1;
    for (int s = 1; s <= 17; s++) begin
      step();
      check("w2.count",  64'(cnt2),  jcode(2, s % 4));
      check("w2.phase",  64'(ph2),   64'(s % 4));
      check("w2.onehot", 64'(oh2),   64'd1 << (s % 4));
      check("w2.wrap",   64'(wrap2), 64'((s % 4) == 0));
      check("w8.count",  64'(cnt8),  jcode(8, s % 16));
      check("w8.phase",  64'(ph8),   64'(s % 16));
      check("w8.onehot", 64'(oh8),   64'd1 << (s % 16));
      check("w8.wrap",   64'(wrap8), 64'((s % 16) == 0));
      check("w8.err",    64'(err8),  64'd0);
    end
    ens = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
